// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter controller and the ALU datapath.
package alu_pkg;

  localparam int unsigned WIDTH_DEFAULT = 8;
  localparam int unsigned G_W           = 4;

  // Arithmetic function codes
  localparam logic [G_W-1:0] G_PASS_A  = 4'd0;
  localparam logic [G_W-1:0] G_INC     = 4'd1;
  localparam logic [G_W-1:0] G_ADD     = 4'd2;
  localparam logic [G_W-1:0] G_ADDC    = 4'd3;
  localparam logic [G_W-1:0] G_ADDNB   = 4'd4;
  localparam logic [G_W-1:0] G_SUB     = 4'd5;
  localparam logic [G_W-1:0] G_DEC     = 4'd6;
  localparam logic [G_W-1:0] G_PASS_A7 = 4'd7;

  // Logic function codes (odd neighbours alias to the even code)
  localparam logic [G_W-1:0] G_AND     = 4'd8;
  localparam logic [G_W-1:0] G_OR      = 4'd10;
  localparam logic [G_W-1:0] G_XOR     = 4'd12;
  localparam logic [G_W-1:0] G_NOT     = 4'd14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/Arithmetic_Logic_Unit.sv
// Combinational ALU: one adder for the arithmetic codes, a bitwise unit for
// the logic codes. G[3] selects logic; for logic codes G[0] is ignored.
module Arithmetic_Logic_Unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic [G_W-1:0]   g_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             c_o,
  output logic             v_o
);

  logic [WIDTH-1:0] addend;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] logic_res;
  logic             is_logic;

  // Pick the second adder operand and carry-in for each arithmetic code
  always_comb begin
    addend = '0;
    cin    = 1'b0;
    case (g_i)
      G_PASS_A, G_PASS_A7: begin
        addend = '0;
        cin    = 1'b0;
      end
      G_INC: cin = 1'b1;
      G_ADD: addend = b_i;
      G_ADDC: begin
        addend = b_i;
        cin    = 1'b1;
      end
      G_ADDNB: addend = ~b_i;
      G_SUB: begin
        addend = ~b_i;
        cin    = 1'b1;
      end
      G_DEC: addend = '1;
      default: begin
        addend = '0;
        cin    = 1'b0;
      end
    endcase
  end

  assign sum = {1'b0, a_i} + {1'b0, addend} + {{WIDTH{1'b0}}, cin};

  // Bitwise operations; bit 0 of the code does not affect them
  always_comb begin
    logic_res = a_i & b_i;
    case ({1'b1, g_i[2:1], 1'b0})
      G_AND:   logic_res = a_i & b_i;
      G_OR:    logic_res = a_i | b_i;
      G_XOR:   logic_res = a_i ^ b_i;
      G_NOT:   logic_res = ~a_i;
      default: logic_res = a_i & b_i;
    endcase
  end

  assign is_logic = g_i[3];

  // Signed overflow: both adder inputs share a sign that the sum does not
  always_comb begin
    result_o = sum[WIDTH-1:0];
    c_o      = sum[WIDTH];
    v_o      = (a_i[WIDTH-1] == addend[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
    if (is_logic) begin
      result_o = logic_res;
      c_o      = 1'b0;
      v_o      = 1'b0;
    end
  end

endmodule

// File: rtl/alu_arbiter_ctrl.sv
// Round-robin controller sharing one ALU between two command requesters.
// IDLE grants and latches a command, EXEC runs the ALU from the latched
// operands and captures the result, RESP holds it until the consumer takes it.
module alu_arbiter_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [G_W-1:0]   req0_g,
  input  logic [G_W-1:0]   req1_g,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_c,
  output logic             rsp_v,
  output logic             rsp_z,
  output logic             busy
);

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic             id_q, id_d;
  logic [G_W-1:0]   g_q, g_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_c_q, rsp_c_d;
  logic             rsp_v_q, rsp_v_d;
  logic             rsp_z_q, rsp_z_d;

  logic             grant_id_c;
  logic [WIDTH-1:0] alu_result;
  logic             alu_c;
  logic             alu_v;

  // Shared ALU, fed only from the latched command
  Arithmetic_Logic_Unit #(
    .WIDTH (WIDTH)
  ) u_alu (
    .g_i      (g_q),
    .a_i      (a_q),
    .b_i      (b_q),
    .result_o (alu_result),
    .c_o      (alu_c),
    .v_o      (alu_v)
  );

  // Round-robin pick: a lone requester wins, otherwise the favoured one
  always_comb begin
    grant_id_c = prio_q;
    if (req_valid == 2'b01) begin
      grant_id_c = 1'b0;
    end else if (req_valid == 2'b10) begin
      grant_id_c = 1'b1;
    end
  end

  // Next-state, command latch and result capture
  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    id_d         = id_q;
    g_d          = g_q;
    a_d          = a_q;
    b_d          = b_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_c_d      = rsp_c_q;
    rsp_v_d      = rsp_v_q;
    rsp_z_d      = rsp_z_q;
    req_ready    = 2'b00;

    case (state_q)
      ST_IDLE: begin
        // Reset overrides any handshake, so never advertise ready during it
        if ((req_valid != 2'b00) && !rst) begin
          req_ready = grant_id_c ? 2'b10 : 2'b01;
          id_d      = grant_id_c;
          prio_d    = ~grant_id_c;
          g_d       = grant_id_c ? req1_g : req0_g;
          a_d       = grant_id_c ? req1_a : req0_a;
          b_d       = grant_id_c ? req1_b : req0_b;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_id_d     = id_q;
        rsp_result_d = alu_result;
        rsp_c_d      = alu_c;
        rsp_v_d      = alu_v;
        rsp_z_d      = (alu_result == '0);
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      prio_q       <= 1'b0;
      id_q         <= 1'b0;
      g_q          <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_c_q      <= 1'b0;
      rsp_v_q      <= 1'b0;
      rsp_z_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      id_q         <= id_d;
      g_q          <= g_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_c_q      <= rsp_c_d;
      rsp_v_q      <= rsp_v_d;
      rsp_z_q      <= rsp_z_d;
    end
  end

  assign rsp_valid  = (state_q == ST_RESP);
  assign busy       = (state_q != ST_IDLE);
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_c      = rsp_c_q;
  assign rsp_v      = rsp_v_q;
  assign rsp_z      = rsp_z_q;

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// Bench for alu_arbiter_ctrl: directed scenarios plus random traffic, checked
// cycle by cycle against a transaction-level model of arbitration and the ALU.
module tb_alu_arbiter_ctrl;

  logic       clk;
  logic       rst;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [3:0] req0_g, req1_g;
  logic [7:0] req0_a, req1_a, req0_b, req1_b;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [7:0] rsp_result;
  logic       rsp_c, rsp_v, rsp_z, busy;

  alu_arbiter_ctrl #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req0_g     (req0_g),
    .req1_g     (req1_g),
    .req0_a     (req0_a),
    .req1_a     (req1_a),
    .req0_b     (req0_b),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_c      (rsp_c),
    .rsp_v      (rsp_v),
    .rsp_z      (rsp_z),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Pending commands per requester, packed {g, a, b}
  logic [19:0] q0[$];
  logic [19:0] q1[$];

  // Transaction model state
  logic        m_busy;
  logic        m_age;      // 0: executing, 1: response presented
  logic        m_ptr;
  logic        m_id;
  logic [10:0] m_exp;      // {c, v, z, result}

  // Observations of retired responses
  logic        last_id;
  logic [7:0]  last_res;
  logic        last_c, last_v, last_z;
  logic        id_log[$];
  logic [7:0]  res_log[$];
  int          busy_cycles;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ALU behaviour from the opcode table, in plain integer arithmetic
  function automatic logic [10:0] model_alu(input logic [3:0] g, input logic [7:0] a,
                                            input logic [7:0] b);
    int u, s, sa, sb;
    logic [7:0] r;
    logic c, v;
    sa = (a >= 8'd128) ? int'(a) - 256 : int'(a);
    sb = (b >= 8'd128) ? int'(b) - 256 : int'(b);
    u = int'(a);
    s = sa;
    c = 1'b0;
    v = 1'b0;
    if (g >= 4'd8) begin
      case (g)
        4'd8, 4'd9:   u = int'(a & b);
        4'd10, 4'd11: u = int'(a | b);
        4'd12, 4'd13: u = int'(a ^ b);
        default:      u = int'(8'(~a));
      endcase
      r = 8'(u);
    end else begin
      case (g)
        4'd1: begin u = int'(a) + 1;             s = sa + 1;      end
        4'd2: begin u = int'(a) + int'(b);       s = sa + sb;     end
        4'd3: begin u = int'(a) + int'(b) + 1;   s = sa + sb + 1; end
        4'd4: begin u = int'(a) + 255 - int'(b); s = sa - sb - 1; end
        4'd5: begin u = int'(a) + 256 - int'(b); s = sa - sb;     end
        4'd6: begin u = int'(a) + 255;           s = sa - 1;      end
        default: begin u = int'(a);              s = sa;          end
      endcase
      r = 8'(u);
      c = (u > 255);
      v = (s > 127) || (s < -128);
    end
    return {c, v, (r == 8'h00), r};
  endfunction

  task automatic drive();
    req_valid[0] = (q0.size() != 0);
    req_valid[1] = (q1.size() != 0);
    if (q0.size() != 0) {req0_g, req0_a, req0_b} = q0[0];
    else                {req0_g, req0_a, req0_b} = 20'($urandom);
    if (q1.size() != 0) {req1_g, req1_a, req1_b} = q1[0];
    else                {req1_g, req1_a, req1_b} = 20'($urandom);
  endtask

  // One clock: check outputs on the falling edge, advance model at the rising edge
  task automatic step();
    logic [1:0]  e_rdy;
    int          gi;
    logic        in_resp;
    logic [19:0] cmd;
    logic        o_id, o_c, o_v, o_z;
    logic [7:0]  o_res;
    @(negedge clk);
    e_rdy = 2'b00;
    gi = -1;
    if (!rst && !m_busy && (req_valid != 2'b00)) begin
      if (req_valid == 2'b01)      gi = 0;
      else if (req_valid == 2'b10) gi = 1;
      else                         gi = int'(m_ptr);
      e_rdy = (gi == 0) ? 2'b01 : 2'b10;
    end
    in_resp = m_busy && m_age;
    chk("req_ready", 32'(req_ready), 32'(e_rdy));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("rsp_valid", 32'(rsp_valid), 32'(in_resp));
    if (in_resp) begin
      chk("rsp_id", 32'(rsp_id), 32'(m_id));
      chk("rsp_result", 32'(rsp_result), 32'(m_exp[7:0]));
      chk("rsp_z", 32'(rsp_z), 32'(m_exp[8]));
      chk("rsp_v", 32'(rsp_v), 32'(m_exp[9]));
      chk("rsp_c", 32'(rsp_c), 32'(m_exp[10]));
    end
    if (busy) busy_cycles++;
    o_id = rsp_id; o_res = rsp_result; o_c = rsp_c; o_v = rsp_v; o_z = rsp_z;
    @(posedge clk);
    if (rst) begin
      m_busy = 1'b0;
      m_age  = 1'b0;
      m_ptr  = 1'b0;
    end else if (gi >= 0) begin
      if (gi == 0) cmd = q0.pop_front();
      else         cmd = q1.pop_front();
      m_exp  = model_alu(cmd[19:16], cmd[15:8], cmd[7:0]);
      m_id   = (gi == 1);
      m_ptr  = (gi == 0);
      m_busy = 1'b1;
      m_age  = 1'b0;
    end else if (m_busy) begin
      if (!m_age) begin
        m_age = 1'b1;
      end else if (rsp_ready) begin
        m_busy = 1'b0;
        last_id = o_id; last_res = o_res; last_c = o_c; last_v = o_v; last_z = o_z;
        id_log.push_back(o_id);
        res_log.push_back(o_res);
      end
    end
    #1;
    drive();
  endtask

  task automatic drain(input string tag);
    logic timed_out;
    timed_out = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if ((q0.size() == 0) && (q1.size() == 0) && !m_busy) begin
        timed_out = 1'b0;
        break;
      end
      step();
    end
    chk(tag, 32'(timed_out), 32'd0);
  endtask

  // All outputs must read zero right after a reset edge
  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".req_ready"},  32'(req_ready),  32'd0);
    chk({tag, ".rsp_valid"},  32'(rsp_valid),  32'd0);
    chk({tag, ".busy"},       32'(busy),       32'd0);
    chk({tag, ".rsp_id"},     32'(rsp_id),     32'd0);
    chk({tag, ".rsp_result"}, 32'(rsp_result), 32'd0);
    chk({tag, ".rsp_c"},      32'(rsp_c),      32'd0);
    chk({tag, ".rsp_v"},      32'(rsp_v),      32'd0);
    chk({tag, ".rsp_z"},      32'(rsp_z),      32'd0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    step();
    chk_reset_outputs(tag);
    rst = 1'b0;
  endtask

  initial begin
    logic reached;
    rst = 1'b1;
    rsp_ready = 1'b1;
    m_busy = 1'b0; m_age = 1'b0; m_ptr = 1'b0; m_id = 1'b0; m_exp = '0;
    busy_cycles = 0;
    drive();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Single request: 0x0A - 0x0A
    busy_cycles = 0;
    q0.push_back({4'd5, 8'h0A, 8'h0A});
    drive();
    drain("single.drain");
    chk("single.result", 32'(last_res), 32'h00);
    chk("single.c", 32'(last_c), 32'd1);
    chk("single.v", 32'(last_v), 32'd0);
    chk("single.z", 32'(last_z), 32'd1);
    chk("single.id", 32'(last_id), 32'd0);
    chk("single.busy_cycles", 32'(busy_cycles), 32'd2);

    // Overflow capture from requester 1
    q1.push_back({4'd2, 8'h80, 8'h80});
    drive();
    drain("ovf.drain");
    chk("ovf.result", 32'(last_res), 32'h00);
    chk("ovf.c", 32'(last_c), 32'd1);
    chk("ovf.v", 32'(last_v), 32'd1);
    chk("ovf.z", 32'(last_z), 32'd1);
    chk("ovf.id", 32'(last_id), 32'd1);

    // Contention after reset: grants alternate starting with 0
    do_reset("cont_reset");
    id_log.delete();
    res_log.delete();
    for (int i = 0; i < 4; i++) begin
      q0.push_back({4'd8, 8'hFF, 8'h0A});
      q1.push_back({4'd8, 8'hFF, 8'h0A});
    end
    drive();
    drain("cont.drain");
    chk("cont.count", 32'(id_log.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < id_log.size()) begin
        chk($sformatf("cont.id%0d", i), 32'(id_log[i]), 32'(i % 2));
        chk($sformatf("cont.res%0d", i), 32'(res_log[i]), 32'h0A);
      end
    end

    // Backpressure: five stalled RESP cycles with a request pending
    rsp_ready = 1'b0;
    q0.push_back({4'd2, 8'h11, 8'h22});
    q0.push_back({4'd12, 8'h5A, 8'hFF});
    drive();
    reached = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (rsp_valid) begin
        reached = 1'b1;
        break;
      end
    end
    chk("bp.reached_resp", 32'(reached), 32'd1);
    repeat (5) step();
    rsp_ready = 1'b1;
    drain("bp.drain");
    chk("bp.last_result", 32'(last_res), 32'hA5);
    chk("bp.last_id", 32'(last_id), 32'd0);

    // Reset during EXEC drops the command and resets the pointer
    id_log.delete();
    q1.push_back({4'd2, 8'h01, 8'h01});
    drive();
    drain("pre_rst.drain");
    q0.push_back({4'd1, 8'hFF, 8'h00});
    drive();
    reached = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (m_busy && !m_age) begin
        reached = 1'b1;
        break;
      end
    end
    chk("midrst.in_exec", 32'(busy && reached), 32'd1);
    do_reset("midrst");
    id_log.delete();
    q0.push_back({4'd2, 8'h03, 8'h04});
    q1.push_back({4'd2, 8'h05, 8'h06});
    drive();
    drain("midrst.drain");
    chk("midrst.count", 32'(id_log.size()), 32'd2);
    if (id_log.size() != 0) chk("midrst.first_id", 32'(id_log[0]), 32'd0);

    // Logic sweep: NOT A
    q0.push_back({4'd14, 8'h0A, 8'($urandom)});
    drive();
    drain("not.drain");
    chk("not.result", 32'(last_res), 32'hF5);
    chk("not.z", 32'(last_z), 32'd0);

    // Random traffic with random backpressure
    for (int i = 0; i < 600; i++) begin
      if (($urandom_range(0, 3) == 0) && (q0.size() < 3)) q0.push_back(20'($urandom));
      if (($urandom_range(0, 3) == 0) && (q1.size() < 3)) q1.push_back(20'($urandom));
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (!req_valid[0] || !req_valid[1]) drive();
      step();
    end
    rsp_ready = 1'b1;
    drain("rand.drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter_ctrl.md
# alu_arbiter_ctrl

Two-requester controller that shares one Arithmetic_Logic_Unit instance between independent command sources. It arbitrates round-robin, latches the winning command's function code and operands, drives the ALU for one execute cycle, and registers the 8-bit result with carry, overflow and zero flags. The result is returned to the winning requester over a valid/ready response channel. It sits between the control front-ends and the shared ALU datapath in the function unit.

## Interface
- WIDTH, 8, operand/result width; must match the ALU width
- clk  in  1  system clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  2  per-requester command valid, bit i = requester i
- req_ready  out  2  per-requester accept; at most one bit high per cycle
- req0_g / req1_g  in  4 each  ALU function code G
- req0_a / req1_a  in  WIDTH each  operand A
- req0_b / req1_b  in  WIDTH each  operand B
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumer accepts
- rsp_id  out  1  index of the requester that issued the command
- rsp_result  out  WIDTH  registered ALU_Result
- rsp_c / rsp_v / rsp_z  out  1 each  registered carry, overflow, zero (result == 0)
- busy  out  1  high in EXEC and RESP

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any req_valid bit is high, grant one requester and assert its req_ready combinationally. The handshake completes on req_valid & req_ready. Latch g/a/b and id, then go to EXEC. If no request is valid, stay in IDLE.
- Arbitration: a 1-bit priority pointer names the favoured requester. A lone valid request always wins. If both are valid, the favoured one wins. After any grant, the pointer moves to the other requester. Reset sets the pointer to 0.
- EXEC: the ALU inputs are driven only from the latched registers, never from req ports. At the end of the cycle, ALU_Result, C and V are captured into the rsp registers and rsp_z = (ALU_Result == 0). Next state is RESP.
- RESP: rsp_valid = 1. All rsp_* outputs stay stable until rsp_valid & rsp_ready, then the FSM returns to IDLE.
- req_ready is 0 in EXEC and RESP. No new command is accepted in the same cycle that the response retires.
- G encoding is passed through unmodified, and all 16 codes are legal. Arithmetic codes:
  - 0/7 pass A
  - 1 A+1
  - 2 A+B
  - 3 A+B+1
  - 4 A+~B
  - 5 A-B (C=1 means no borrow)
  - 6 A-1
- Logic codes: 8 AND, 10 OR, 12 XOR, 14 NOT A.
- The controller does not interpret flags. It records whatever the ALU reports.
- Reset: applies at any point, including mid-EXEC or mid-RESP. The in-flight command is dropped without a response, the FSM goes to IDLE, and the pointer resets to 0. All outputs are 0 (req_ready, rsp_valid, rsp_id, rsp_result, rsp_c, rsp_v, rsp_z, busy), except req_ready, which may assert combinationally in IDLE in the first cycle after reset deasserts.

## Timing
- Accept edge N -> EXEC during cycle N+1 -> rsp_valid high from cycle N+2.
- Minimum turnaround is 3 cycles per command when rsp_ready is held high, so the next req_ready is earliest at cycle N+3.
- rsp_ready low stalls indefinitely in RESP. Pending requests wait; req_valid must hold its command stable until accepted.
- If both requests stay asserted continuously, grants alternate 0,1,0,1.

## Structure
- Shared package (alu_pkg): the 4-bit G opcode constants listed above, the FSM state enum, and the WIDTH default.
- One sub-module: the existing Arithmetic_Logic_Unit, instantiated once.
- The arbiter, FSM and capture registers live in this module, with no further sub-modules.

## Test plan
- Single request: req0 with G=5, A=0x0A, B=0x0A; rsp_ready held high. Required: rsp_valid at N+2 with result 0x00, C=1, V=0, Z=1, id=0. busy is high for 2 cycles.
- Overflow capture: req1 with G=2, A=0x80, B=0x80. Required: result 0x00, C=1, V=1, Z=1, id=1.
- Contention: both requesters hold valid for 4 commands each (G=8, A=0xFF, B=0x0A). Required: ids alternate 0,1,0,… starting with 0 after reset, and every result is 0x0A.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP with req0 pending. Required: rsp_* outputs stable and req_ready=0 throughout; the pending command is accepted the cycle after the FSM returns to IDLE.
- Reset mid-operation: assert rst during EXEC of G=1, A=0xFF. Required: no rsp_valid and all outputs 0 the next cycle; the next request is granted to requester 0 when both are valid.
- Logic sweep: G=14 with A=0x0A through requester 0. Required: result 0xF5, Z=0.
